// File: rtl/dmem_lock_arbiter.sv
// Round-robin arbiter sharing one data-memory port between two cores, with per-core AMO word locks.
// Define DMEM_LOCK_TIMEOUT_EN to force-release a lock held for LOCK_TIMEOUT cycles.
module dmem_lock_arbiter
`ifdef DMEM_LOCK_TIMEOUT_EN
#(
    parameter int unsigned LOCK_TIMEOUT = 32'd1024
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic        c0_read,
    input  logic        c0_write,
    input  logic [31:0] c0_addr,
    input  logic [31:0] c0_wdata,
    input  logic [3:0]  c0_wmask,
    input  logic        c0_lock,
    output logic [31:0] c0_rdata,
    output logic        c0_resp,
    input  logic        c1_read,
    input  logic        c1_write,
    input  logic [31:0] c1_addr,
    input  logic [31:0] c1_wdata,
    input  logic [3:0]  c1_wmask,
    input  logic        c1_lock,
    output logic [31:0] c1_rdata,
    output logic        c1_resp,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        rr_ptr_r;
    logic        owner_r;
    logic        lat_lock_r;
    logic [1:0]  lock_held_r;
    logic [29:0] lock_word_r [2];

    logic [1:0]  req_s;
    logic [1:0]  rd_s;
    logic [1:0]  lock_s;
    logic [1:0]  eligible_s;
    logic [1:0]  acq_s;
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [3:0]  wmask_s [2];
    logic        grant_s;
    logic        grant_id_s;
    logic        done_s;

`ifdef DMEM_LOCK_TIMEOUT_EN
    logic [31:0] lock_cnt_r [2];
`endif

    // Gather per-core request fields; a core is only ever blocked by the other core's lock.
    always_comb begin
        rd_s       = {c1_read, c0_read};
        req_s      = {c1_read | c1_write, c0_read | c0_write};
        lock_s     = {c1_lock, c0_lock};
        addr_s[0]  = c0_addr;
        addr_s[1]  = c1_addr;
        wdata_s[0] = c0_wdata;
        wdata_s[1] = c1_wdata;
        wmask_s[0] = c0_wmask;
        wmask_s[1] = c1_wmask;
        eligible_s[0] = req_s[0] & ~(lock_held_r[1] & (c0_addr[31:2] == lock_word_r[1]));
        eligible_s[1] = req_s[1] & ~(lock_held_r[0] & (c1_addr[31:2] == lock_word_r[0]));
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and grant selection.
    always_comb begin
        state_next_s = state_r;
        grant_s      = 1'b0;
        grant_id_s   = rr_ptr_r;
        done_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (eligible_s == 2'b11) begin
                    grant_s      = 1'b1;
                    grant_id_s   = rr_ptr_r;
                    state_next_s = BUSY;
                end else if (eligible_s[0]) begin
                    grant_s      = 1'b1;
                    grant_id_s   = 1'b0;
                    state_next_s = BUSY;
                end else if (eligible_s[1]) begin
                    grant_s      = 1'b1;
                    grant_id_s   = 1'b1;
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    done_s       = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Completion goes straight back to the owner in the cycle memory responds.
    assign c0_resp  = done_s & ~owner_r;
    assign c1_resp  = done_s & owner_r;
    assign c0_rdata = c0_resp ? mem_rdata : 32'h0000_0000;
    assign c1_rdata = c1_resp ? mem_rdata : 32'h0000_0000;

    // Memory-side address phase, owner and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r   <= 1'b0;
            owner_r    <= 1'b0;
            lat_lock_r <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= 32'h0000_0000;
            mem_wdata  <= 32'h0000_0000;
            mem_wmask  <= 4'h0;
        end else if (grant_s) begin
            owner_r    <= grant_id_s;
            lat_lock_r <= lock_s[grant_id_s];
            mem_read   <= rd_s[grant_id_s];
            mem_write  <= ~rd_s[grant_id_s];
            mem_addr   <= addr_s[grant_id_s];
            mem_wdata  <= wdata_s[grant_id_s];
            mem_wmask  <= wmask_s[grant_id_s];
        end else if (done_s) begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            rr_ptr_r   <= ~owner_r;
        end
    end

    assign acq_s[0] = done_s & mem_read & lat_lock_r & ~owner_r & c0_lock;
    assign acq_s[1] = done_s & mem_read & lat_lock_r &  owner_r & c1_lock;

    // Lock table: acquired by a completed locked read, dropped whenever the core lowers its lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_held_r <= 2'b00;
            for (int n = 0; n < 2; n++) begin
                lock_word_r[n] <= 30'd0;
`ifdef DMEM_LOCK_TIMEOUT_EN
                lock_cnt_r[n]  <= 32'd0;
`endif
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (!lock_s[n]) begin
                    lock_held_r[n] <= 1'b0;
                end else if (acq_s[n]) begin
                    lock_held_r[n] <= 1'b1;
                    lock_word_r[n] <= mem_addr[31:2];
`ifdef DMEM_LOCK_TIMEOUT_EN
                end else if (lock_held_r[n] && (lock_cnt_r[n] == (LOCK_TIMEOUT - 32'd1))) begin
                    lock_held_r[n] <= 1'b0;
`endif
                end
`ifdef DMEM_LOCK_TIMEOUT_EN
                if (acq_s[n]) begin
                    lock_cnt_r[n] <= 32'd0;
                end else if (lock_held_r[n]) begin
                    lock_cnt_r[n] <= lock_cnt_r[n] + 32'd1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_dmem_lock_arbiter.sv
// Directed bench for dmem_lock_arbiter: cycle-level reference model plus hand-computed checks.
module tb_dmem_lock_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        c_rd [2];
    logic        c_wr [2];
    logic        c_lk [2];
    logic [31:0] c_ad [2];
    logic [31:0] c_wd [2];
    logic [3:0]  c_wm [2];
    logic [31:0] c0_rdata, c1_rdata;
    logic        c0_resp, c1_resp;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_resp = 1'b0;

    int n_run = 0;
    int n_fail = 0;
    int resp_log[$];
    bit resp_en = 1'b1;
    int mem_lat = 2;
    logic [31:0] mem_arr [logic [29:0]];

`ifdef DMEM_LOCK_TIMEOUT_EN
    dmem_lock_arbiter #(.LOCK_TIMEOUT(TO)) dut (
`else
    dmem_lock_arbiter dut (
`endif
        .clk(clk), .rst(rst),
        .c0_read(c_rd[0]), .c0_write(c_wr[0]), .c0_addr(c_ad[0]), .c0_wdata(c_wd[0]),
        .c0_wmask(c_wm[0]), .c0_lock(c_lk[0]), .c0_rdata(c0_rdata), .c0_resp(c0_resp),
        .c1_read(c_rd[1]), .c1_write(c_wr[1]), .c1_addr(c_ad[1]), .c1_wdata(c_wd[1]),
        .c1_wmask(c_wm[1]), .c1_lock(c_lk[1]), .c1_rdata(c1_rdata), .c1_resp(c1_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [29:0] w);
        return mem_arr.exists(w) ? mem_arr[w] : 32'h0;
    endfunction

    // Memory responder: answers a strobe after mem_lat cycles with a one-cycle mem_resp.
    initial begin : responder
        int cnt;
        logic [31:0] v;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_resp) begin
                mem_resp  = 1'b0;
                mem_rdata = 32'h0;
                cnt = 0;
            end else if (resp_en && (mem_read || mem_write)) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    if (mem_write) begin
                        v = rd_word(mem_addr[31:2]);
                        for (int b = 0; b < 4; b++)
                            if (mem_wmask[b]) v[b*8 +: 8] = mem_wdata[b*8 +: 8];
                        mem_arr[mem_addr[31:2]] = v;
                    end
                    mem_rdata = mem_read ? rd_word(mem_addr[31:2]) : 32'h0;
                    mem_resp  = 1'b1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Reference model: one transaction at a time, alternating priority, per-core word locks.
    initial begin : model
        bit ok, busy, own, op_rd, lk, prio, done, e_r0, e_r1;
        logic [31:0] a, d;
        logic [3:0] m;
        bit held [2];
        logic [29:0] word [2];
        int t_acq [2];
        bit want [2];
        int pick, cyc;
        ok = 0; cyc = 0; busy = 0; own = 0; op_rd = 0; lk = 0; prio = 0;
        a = 0; d = 0; m = 0;
        for (int n = 0; n < 2; n++) begin held[n] = 0; word[n] = 0; t_acq[n] = 0; end
        forever begin
            @(negedge clk);
            if (c0_resp) resp_log.push_back(0);
            if (c1_resp) resp_log.push_back(1);
            if (ok) begin
                e_r0 = busy && mem_resp && !own;
                e_r1 = busy && mem_resp && own;
                chk("model mem_read", 32'(mem_read), 32'(busy && op_rd));
                chk("model mem_write", 32'(mem_write), 32'(busy && !op_rd));
                chk("model mem_addr", mem_addr, a);
                chk("model mem_wdata", mem_wdata, d);
                chk("model mem_wmask", 32'(mem_wmask), 32'(m));
                chk("model c0_resp", 32'(c0_resp), 32'(e_r0));
                chk("model c1_resp", 32'(c1_resp), 32'(e_r1));
                chk("model c0_rdata", c0_rdata, e_r0 ? mem_rdata : 32'h0);
                chk("model c1_rdata", c1_rdata, e_r1 ? mem_rdata : 32'h0);
            end
            if (rst) begin
                ok = 1; busy = 0; own = 0; op_rd = 0; lk = 0; prio = 0; a = 0; d = 0; m = 0;
                for (int n = 0; n < 2; n++) begin held[n] = 0; word[n] = 0; end
            end else if (ok) begin
                done = busy && mem_resp;
                for (int n = 0; n < 2; n++)
                    want[n] = (c_rd[n] || c_wr[n]) && !(held[1-n] && c_ad[n][31:2] == word[1-n]);
                for (int n = 0; n < 2; n++) begin
                    if (!c_lk[n]) held[n] = 0;
                    else if (done && int'(own) == n && op_rd && lk) begin
                        held[n] = 1; word[n] = a[31:2]; t_acq[n] = cyc + 1;
                    end
`ifdef DMEM_LOCK_TIMEOUT_EN
                    else if (held[n] && (cyc + 1 - t_acq[n]) >= TO) held[n] = 0;
`endif
                end
                if (busy) begin
                    if (mem_resp) begin busy = 0; prio = !own; end
                end else if (want[0] || want[1]) begin
                    pick = (want[0] && want[1]) ? int'(prio) : (want[0] ? 0 : 1);
                    busy = 1; own = (pick == 1); op_rd = c_rd[pick]; lk = c_lk[pick];
                    a = c_ad[pick]; d = c_wd[pick]; m = c_wm[pick];
                end
            end
            cyc++;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int n = 0; n < 2; n++) begin
            c_rd[n] = 0; c_wr[n] = 0; c_lk[n] = 0; c_ad[n] = 0; c_wd[n] = 0; c_wm[n] = 0;
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Issue one core request and hold it until its completion (bounded wait).
    task automatic core_op(input int c, input bit wr, input logic [31:0] ad, input logic [31:0] wd,
                           input bit lk, output logic [31:0] rdat);
        bit got;
        got = 0; rdat = 32'h0;
        c_ad[c] = ad; c_wd[c] = wd; c_wm[c] = 4'hF; c_lk[c] = lk; c_rd[c] = !wr; c_wr[c] = wr;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (c == 0 ? c0_resp : c1_resp) begin
                got = 1; rdat = (c == 0) ? c0_rdata : c1_rdata;
            end
        end
        chk($sformatf("c%0d completes 0x%08h", c, ad), 32'(got), 32'd1);
        @(posedge clk); #1;
        c_rd[c] = 0; c_wr[c] = 0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] r0, r1;
        int first_rd, resp_k, k_w, n_log;
        bit bad;
        mem_arr[30'h100 >> 2] = 32'hDEAD_BEEF;
        mem_arr[30'h204 >> 2] = 32'h0204_A5A5;
        mem_arr[30'h300 >> 2] = 32'hAAAA_0000;
        mem_arr[30'h400 >> 2] = 32'h4040_4040;
        mem_arr[30'h600 >> 2] = 32'h6060_6060;
        for (int n = 0; n < 2; n++) begin
            c_rd[n] = 0; c_wr[n] = 0; c_lk[n] = 0; c_ad[n] = 0; c_wd[n] = 0; c_wm[n] = 0;
        end
        do_reset();
        @(negedge clk);
        chk("reset mem_read", 32'(mem_read), 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset c0_resp", 32'(c0_resp), 32'd0);

        // 1: single read, strobe one cycle after request, response two cycles after
        @(posedge clk); #1;
        first_rd = 0; resp_k = 0; r0 = 0;
        c_ad[0] = 32'h100; c_rd[0] = 1;
        for (int k = 1; k <= 20 && resp_k == 0; k++) begin
            @(negedge clk);
            if (mem_read && first_rd == 0) first_rd = k;
            if (c0_resp) begin resp_k = k; r0 = c0_rdata; end
        end
        chk("t1 strobe cycle", 32'(first_rd), 32'd2);
        chk("t1 resp cycle", 32'(resp_k), 32'd3);
        chk("t1 rdata", r0, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        c_rd[0] = 0;
        resp_log.delete();
        fork
            core_op(0, 0, 32'h108, 32'h0, 0, r0);
            core_op(1, 0, 32'h10C, 32'h0, 0, r1);
        join
        chk("t1 rr first is c1", 32'(resp_log[0]), 32'd1);
        chk("t1 rr second is c0", 32'(resp_log[1]), 32'd0);

        // 2: both cores contend, alternating grants from reset
        do_reset();
        resp_log.delete();
        fork
            begin core_op(0, 0, 32'h10, 0, 0, r0); core_op(0, 0, 32'h14, 0, 0, r0); end
            begin core_op(1, 0, 32'h20, 0, 0, r1); core_op(1, 0, 32'h24, 0, 0, r1); end
        join
        chk("t2 grant count", 32'(resp_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < resp_log.size(); i++)
            chk($sformatf("t2 grant %0d", i), 32'(resp_log[i]), 32'(i % 2));

        // 3: c0 lock blocks c1 on the same word only
        do_reset();
        core_op(0, 0, 32'h200, 0, 1, r0);
        core_op(1, 0, 32'h204, 0, 0, r1);
        chk("t3 other word read", r1, 32'h0204_A5A5);
        bad = 0; k_w = 0;
        fork
            core_op(1, 1, 32'h200, 32'hCAFE_F00D, 0, r1);
            begin
                for (int k = 0; k < 12; k++) begin
                    @(negedge clk);
                    if (mem_write) bad = 1;
                end
                chk("t3 blocked write", 32'(bad), 32'd0);
                @(posedge clk); #1;
                c_lk[0] = 0;
                for (int k = 1; k <= 20 && k_w == 0; k++) begin
                    @(negedge clk);
                    if (mem_write) k_w = k;
                end
                chk("t3 write after release", 32'(k_w), 32'd3);
            end
        join
        chk("t3 memory written", mem_arr[30'h200 >> 2], 32'hCAFE_F00D);

        // 4: simultaneous lock-reads of one word, c0 wins and updates before c1 sees it
        do_reset();
        resp_log.delete();
        fork
            begin
                core_op(0, 0, 32'h300, 0, 1, r0);
                core_op(0, 1, 32'h300, 32'h1234_5678, 1, r0);
                c_lk[0] = 0;
            end
            core_op(1, 0, 32'h300, 0, 1, r1);
        join
        c_lk[1] = 0;
        chk("t4 c1 sees store", r1, 32'h1234_5678);
        chk("t4 order 0", 32'(resp_log[0]), 32'd0);
        chk("t4 order 1", 32'(resp_log[1]), 32'd0);
        chk("t4 order 2", 32'(resp_log[2]), 32'd1);

        // 5: reset during BUSY abandons the access and clears locks
        do_reset();
        core_op(0, 0, 32'h600, 0, 1, r0);
        resp_en = 0;
        c_ad[0] = 32'h500; c_rd[0] = 1;
        bad = 1;
        for (int k = 0; k < 10 && bad; k++) begin
            @(negedge clk);
            if (mem_read) bad = 0;
        end
        chk("t5 strobe seen", 32'(bad), 32'd0);
        n_log = resp_log.size();
        @(posedge clk); #1;
        rst = 1; c_rd[0] = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("t5 strobe dropped", 32'(mem_read), 32'd0);
        mem_rdata = 32'hBAD0_BAD0;
        mem_resp = 1;
        repeat (3) @(negedge clk);
        chk("t5 no late resp", 32'(resp_log.size()), 32'(n_log));
        resp_en = 1;
        @(posedge clk); #1;
        core_op(1, 0, 32'h600, 0, 0, r1);
        chk("t5 lock cleared", r1, 32'h6060_6060);
        c_lk[0] = 0;

`ifdef DMEM_LOCK_TIMEOUT_EN
        // 6: lock is force-released after TO cycles while c0_lock stays high
        do_reset();
        core_op(0, 0, 32'h400, 0, 1, r0);
        k_w = 0;
        fork
            core_op(1, 0, 32'h400, 0, 0, r1);
            for (int k = 1; k <= 40 && k_w == 0; k++) begin
                @(negedge clk);
                if (mem_read) k_w = k;
            end
        join
        chk("t6 timeout grant cycle", 32'(k_w), 32'd10);
        chk("t6 c1 rdata", r1, 32'h4040_4040);
        c_lk[0] = 0;
`endif

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
